// File: rtl/pc_fetch_unit.sv
// Program counter owner and instruction fetch sequencer: fetches one word,
// holds it for decode/execute, then commits the next PC when the datapath retires.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC    = 32'h0000_3000,
    parameter logic [31:0] EXC_VEC     = 32'h0000_4180,
    parameter bit          CHECK_ALIGN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [5:0]  op,
    output logic [5:0]  funct,
    output logic        instr_valid,
    input  logic        ex_stall,
    input  logic [3:0]  npc_op,
    input  logic [31:0] rs_data,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic        addr_err,
    output logic        illegal_npc
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC
    } state_t;

    state_t state, state_nx;

    logic        load_instr;
    logic        retire;
    logic [31:0] branch_off;
    logic [31:0] target;
    logic        target_checked;
    logic        npc_bad;
    logic        misaligned;
    logic [31:0] pc_commit;

    assign pc_plus4   = pc + 32'd4;
    assign imem_addr  = pc;
    assign op         = instr[31:26];
    assign funct      = instr[5:0];
    assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

    always_comb begin
        state_nx    = state;
        imem_req    = 1'b0;
        instr_valid = 1'b0;
        load_instr  = 1'b0;
        retire      = 1'b0;
        case (state)
            S_IDLE: state_nx = S_FETCH;
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) begin
                    load_instr = 1'b1;
                    state_nx   = S_EXEC;
                end
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!ex_stall) begin
                    retire   = 1'b1;
                    state_nx = S_FETCH;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        target         = pc_plus4;
        target_checked = 1'b0;
        npc_bad        = 1'b0;
        case (npc_op)
            4'b0000: target = pc_plus4;
            4'b0001: begin
                target         = pc_plus4 + branch_off;
                target_checked = 1'b1;
            end
            4'b0010: target = {pc_plus4[31:28], instr[25:0], 2'b00};
            4'b0011, 4'b0100: begin
                target         = rs_data;
                target_checked = 1'b1;
            end
            default: npc_bad = 1'b1;
        endcase
    end

    // With the trap disabled a misaligned target is silently rounded down.
    assign misaligned = target_checked && (target[1:0] != 2'b00);
    assign pc_commit  = !misaligned ? target
                      : (CHECK_ALIGN ? EXC_VEC : {target[31:2], 2'b00});

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            addr_err    <= 1'b0;
            illegal_npc <= 1'b0;
        end else begin
            state       <= state_nx;
            addr_err    <= retire && misaligned && CHECK_ALIGN;
            illegal_npc <= retire && npc_bad;
            if (load_instr) begin
                instr <= imem_rdata;
            end
            if (retire) begin
                pc <= pc_commit;
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: two instances (alignment trap on / off) share stimulus
// and are checked every cycle against a transaction-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam logic [31:0] EXC    = 32'h0000_4180;

    logic        clk;
    logic        rst;
    logic        ack;
    logic [31:0] rdata;
    logic        stall;
    logic [3:0]  npc;
    logic [31:0] rs;

    logic        req     [2];
    logic [31:0] addr    [2];
    logic [31:0] instr_o [2];
    logic [5:0]  op_o    [2];
    logic [5:0]  funct_o [2];
    logic        iv      [2];
    logic [31:0] pc_o    [2];
    logic [31:0] pc4     [2];
    logic        aerr    [2];
    logic        ill     [2];

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_unit #(.RESET_PC(RST_PC), .EXC_VEC(EXC), .CHECK_ALIGN(1'b1)) dut0 (
        .clk(clk), .rst(rst), .imem_req(req[0]), .imem_addr(addr[0]),
        .imem_ack(ack), .imem_rdata(rdata), .instr(instr_o[0]), .op(op_o[0]),
        .funct(funct_o[0]), .instr_valid(iv[0]), .ex_stall(stall), .npc_op(npc),
        .rs_data(rs), .pc(pc_o[0]), .pc_plus4(pc4[0]), .addr_err(aerr[0]),
        .illegal_npc(ill[0])
    );

    pc_fetch_unit #(.RESET_PC(RST_PC), .EXC_VEC(EXC), .CHECK_ALIGN(1'b0)) dut1 (
        .clk(clk), .rst(rst), .imem_req(req[1]), .imem_addr(addr[1]),
        .imem_ack(ack), .imem_rdata(rdata), .instr(instr_o[1]), .op(op_o[1]),
        .funct(funct_o[1]), .instr_valid(iv[1]), .ex_stall(stall), .npc_op(npc),
        .rs_data(rs), .pc(pc_o[1]), .pc_plus4(pc4[1]), .addr_err(aerr[1]),
        .illegal_npc(ill[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = waiting to fetch, 1 = fetching, 2 = holding instruction.
    logic [31:0] m_pc    [2];
    logic [31:0] m_instr [2];
    int          m_ph    [2];
    logic        m_aerr  [2];
    logic        m_ill   [2];
    bit          m_live = 0;

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_pc[i] = RST_PC; m_instr[i] = 0; m_ph[i] = 0;
                m_aerr[i] = 0; m_ill[i] = 0;
            end else begin
                m_aerr[i] = 0;
                m_ill[i]  = 0;
                if (m_ph[i] == 0) begin
                    m_ph[i] = 1;
                end else if (m_ph[i] == 1) begin
                    if (ack) begin
                        m_instr[i] = rdata;
                        m_ph[i] = 2;
                    end
                end else if (!stall) begin
                    logic [31:0] link, t;
                    bit checked;
                    link = m_pc[i] + 4;
                    t = link;
                    checked = 0;
                    case (npc)
                        4'd0: t = link;
                        4'd1: begin
                            t = link + 32'(int'($signed(m_instr[i][15:0])) * 4);
                            checked = 1;
                        end
                        4'd2: t = (link & 32'hF000_0000) | ((m_instr[i] & 32'h03FF_FFFF) << 2);
                        4'd3, 4'd4: begin t = rs; checked = 1; end
                        default: m_ill[i] = 1;
                    endcase
                    if (checked && (t % 4 != 0)) begin
                        if (i == 0) begin
                            t = EXC;
                            m_aerr[i] = 1;
                        end else begin
                            t = t - (t % 4);
                        end
                    end
                    m_pc[i] = t;
                    m_ph[i] = 1;
                end
            end
        end
        m_live = 1;
    end

    always @(negedge clk) begin
        if (m_live) begin
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dut%0d_req", i), req[i], m_ph[i] == 1);
                chk($sformatf("dut%0d_valid", i), iv[i], m_ph[i] == 2);
                chk($sformatf("dut%0d_pc", i), pc_o[i], m_pc[i]);
                chk($sformatf("dut%0d_pc4", i), pc4[i], m_pc[i] + 4);
                chk($sformatf("dut%0d_instr", i), instr_o[i], m_instr[i]);
                chk($sformatf("dut%0d_addr_err", i), aerr[i], m_aerr[i]);
                chk($sformatf("dut%0d_illegal", i), ill[i], m_ill[i]);
                if (m_ph[i] == 1)
                    chk($sformatf("dut%0d_imem_addr", i), addr[i], m_pc[i]);
                if (m_ph[i] == 2) begin
                    chk($sformatf("dut%0d_op", i), op_o[i], m_instr[i] >> 26);
                    chk($sformatf("dut%0d_funct", i), funct_o[i], m_instr[i] % 64);
                end
            end
        end
    end

    task automatic wait_fetch();
        for (int k = 0; k < 20 && req[0] !== 1'b1; k++) @(negedge clk);
        chk("wait_fetch", req[0], 1'b1);
    endtask

    // Called at a negedge in the fetch phase; returns at the next fetch-phase negedge.
    task automatic step_instr(input logic [31:0] w, input logic [3:0] code, input logic [31:0] rsv);
        wait_fetch();
        rdata = w; ack = 1'b1; stall = 1'b0;
        @(negedge clk);
        npc = code; rs = rsv; ack = 1'($urandom); rdata = $urandom;
        @(negedge clk);
        ack = 1'b1;
    endtask

    initial begin
        rst = 1'b1; ack = 1'b1; rdata = '0; stall = 1'b0; npc = '0; rs = '0;
        @(negedge clk);
        chk("reset_pc", pc_o[0], RST_PC);
        chk("reset_req", req[0], 1'b0);
        chk("reset_instr", instr_o[0], 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Sequential fetch, two cycles per instruction.
        chk("t1_addr0", addr[0], 32'h3000);
        step_instr($urandom, 4'd0, '0);
        chk("t1_addr1", addr[0], 32'h3004);
        step_instr($urandom, 4'd0, '0);
        chk("t1_addr2", addr[0], 32'h3008);
        step_instr($urandom, 4'd0, '0);
        step_instr($urandom, 4'd0, '0);

        // Branches: backward by one word, forward by two.
        chk("t2_pc_start", addr[0], 32'h3010);
        step_instr(32'h1000_FFFF, 4'd1, '0);
        chk("t2_back", addr[0], 32'h3010);
        step_instr(32'h1000_0002, 4'd1, '0);
        chk("t2_fwd", addr[0], 32'h301C);

        // Jump from a fresh reset.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        wait_fetch();
        chk("t3_pc_start", addr[0], 32'h3000);
        step_instr(32'h0800_0C40, 4'd2, '0);
        chk("t3_jump", addr[0], 32'h3100);

        // Misaligned JR: trap on dut0, rounded on dut1.
        step_instr(32'h03E0_0008, 4'd3, 32'h0000_3006);
        chk("t4_trap_pc", addr[0], EXC);
        chk("t4_trap_pulse", aerr[0], 1'b1);
        chk("t4_noalign_pc", addr[1], 32'h3004);
        chk("t4_noalign_pulse", aerr[1], 1'b0);

        // Stall hold with npc_op toggling.
        rdata = 32'hDEAD_BEEF; ack = 1'b1;
        @(negedge clk);
        chk("t4_pulse_end", aerr[0], 1'b0);
        for (int k = 0; k < 5; k++) begin
            stall = 1'b1; npc = 4'($urandom_range(0, 7)); rs = $urandom; ack = 1'($urandom);
            @(negedge clk);
            chk("t5_hold_pc", pc_o[0], EXC);
            chk("t5_hold_instr", instr_o[0], 32'hDEAD_BEEF);
            chk("t5_hold_pc4", pc4[0], EXC + 32'd4);
        end
        stall = 1'b0; npc = 4'd0; ack = 1'b1;
        @(negedge clk);
        chk("t5_commit", addr[0], EXC + 32'd4);

        // Delayed ack with reset in the second wait cycle; ack in the reset cycle is dropped.
        ack = 1'b0; rdata = 32'hBAD0_0001;
        @(negedge clk);
        rst = 1'b1; ack = 1'b1; rdata = 32'hBAD0_0002;
        @(negedge clk);
        rst = 1'b0; ack = 1'b1; rdata = 32'hBAD0_0003;
        chk("t6_req_drop", req[0], 1'b0);
        chk("t6_pc_reset", pc_o[0], RST_PC);
        chk("t6_instr_clear", instr_o[0], 32'h0);
        @(negedge clk);
        chk("t6_refetch_addr", addr[0], 32'h3000);
        step_instr(32'h2408_0005, 4'd0, '0);
        chk("t6_clean_instr", instr_o[0], 32'h2408_0005);

        // Wrap past the top of the address space, then an illegal code.
        step_instr($urandom, 4'd3, 32'hFFFF_FFFC);
        chk("t7_top", addr[0], 32'hFFFF_FFFC);
        step_instr($urandom, 4'd0, '0);
        chk("t7_wrap", addr[0], 32'h0);
        step_instr($urandom, 4'd9, '0);
        chk("t7_illegal_pc", addr[0], 32'h4);
        chk("t7_illegal_pulse", ill[0], 1'b1);

        // Randomized traffic.
        for (int c = 0; c < 3000; c++) begin
            int r;
            rst   = ($urandom_range(0, 199) == 0);
            ack   = ($urandom_range(0, 2) != 0);
            stall = ($urandom_range(0, 3) == 0);
            rdata = $urandom;
            r     = $urandom_range(0, 15);
            npc   = (r < 11) ? 4'(r % 5) : 4'($urandom_range(5, 15));
            rs    = ($urandom & 32'hFFFF_FFFC) | (($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : 32'd0);
            @(negedge clk);
        end
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
